// File: rtl/psum_requant_pkg.sv
// Shared constants, row types and requantization arithmetic for the
// partial-sum requant unit and its output FIFO.
//   COLS, PSUM_W, ACT_W, DEPTH : datapath geometry
//   ACT_MAX                    : largest activation value (2^ACT_W-1)
//   psum_row_t / act_row_t     : one row of partial sums / activations
//   requant()                  : ReLU, rounding right-shift, saturation
package psum_requant_pkg;

   localparam int unsigned COLS      = 8;
   localparam int unsigned PSUM_W    = 18;
   localparam int unsigned ACT_W     = 7;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned ROW_IDX_W = 6;
   localparam int unsigned ACT_MAX   = (1 << ACT_W) - 1;
   localparam int unsigned ROW_W     = COLS * ACT_W + ROW_IDX_W;

   typedef logic [COLS-1:0][PSUM_W-1:0] psum_row_t;
   typedef logic [COLS-1:0][ACT_W-1:0]  act_row_t;
   typedef logic signed [PSUM_W+1:0]    psum_ext_t;

   // Two guard bits keep psum + bias + rounding constant from overflowing.
   function automatic logic [ACT_W-1:0] requant(input psum_ext_t v, input logic [3:0] shift);
      logic [PSUM_W+1:0] rnd;
      logic [PSUM_W+1:0] r;
      logic [ACT_W-1:0]  res;
      rnd = '0;
      if (shift != 4'd0)
         rnd = (PSUM_W+2)'(1) << (shift - 4'd1);
      r = ($unsigned(v) + rnd) >> shift;
      if (v[PSUM_W+1])
         res = '0;
      else if (r > (PSUM_W+2)'(ACT_MAX))
         res = ACT_W'(ACT_MAX);
      else
         res = r[ACT_W-1:0];
      return res;
   endfunction

endpackage

// File: rtl/psum_row_fifo.sv
// First-word-fall-through FIFO holding requantized rows (data + row index).
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush
//   push/wdata : write request; accepted when not full or when popping
//   pop        : remove head; ignored when empty
//   rdata      : head entry, zero while empty
//   full, empty, count : occupancy status
module psum_row_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 62
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign count   = cnt;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/psum_requant_unit.sv
// Deskews column-staggered final partial sums into rows, requantizes them
// (ReLU, rounding right-shift, saturation to ACT_W bits) and streams the
// rows out through an FWFT FIFO with valid/ready.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : clear job state, sample shift_amt and num_rows
//   psum_in, psum_vld   : per-column partial sums and skewed valids
//   bias_in             : per-column signed bias (PSUM_REQ_BIAS_EN only)
//   out_data, out_row   : FIFO head row and its index
//   out_valid/out_ready : output handshake
//   done                : pulse on pop of row num_rows-1
//   overflow, skew_err  : sticky error flags
// Optional feature macro: PSUM_REQ_BIAS_EN (adds bias before ReLU).
module psum_requant_unit
   import psum_requant_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [3:0]               shift_amt,
   input  logic [5:0]               num_rows,
   input  logic [COLS*PSUM_W-1:0]   psum_in,
   input  logic [COLS-1:0]          psum_vld,
`ifdef PSUM_REQ_BIAS_EN
   input  logic [COLS*PSUM_W-1:0]   bias_in,
`endif
   output logic [COLS*ACT_W-1:0]    out_data,
   output logic [5:0]               out_row,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     done,
   output logic                     overflow,
   output logic                     skew_err
);

   psum_row_t                 psum_cols;
   psum_row_t                 row_reg;
   logic [COLS-1:0]           mask;
   logic                      complete;
   logic                      row_done;
   logic [3:0]                sh_q;
   logic [5:0]                nrows_q;
   logic [5:0]                row_cnt;
   logic                      req_vld;
   act_row_t                  req_data;
   act_row_t                  act_next;
   psum_ext_t                 v_ext;
   logic                      pop;
   logic                      push_ok;
   logic                      drop;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [ROW_W-1:0]          fifo_rdata;
   logic [$clog2(DEPTH):0]    fifo_count_unused;

   assign psum_cols = psum_in;
   assign complete  = &(mask | psum_vld);

`ifdef PSUM_REQ_BIAS_EN
   psum_row_t bias_cols;
   assign bias_cols = bias_in;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q    <= '0;
         nrows_q <= '0;
      end else if (start) begin
         sh_q    <= shift_amt;
         nrows_q <= num_rows;
      end
   end

   // Deskew: a start in the same cycle as column valids discards them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_reg  <= '0;
         mask     <= '0;
         row_done <= 1'b0;
         skew_err <= 1'b0;
      end else if (start) begin
         mask     <= '0;
         row_done <= 1'b0;
         skew_err <= 1'b0;
      end else begin
         for (int unsigned j = 0; j < COLS; j++) begin
            if (psum_vld[j])
               row_reg[j] <= psum_cols[j];
         end
         if (|(mask & psum_vld))
            skew_err <= 1'b1;
         mask     <= complete ? '0 : (mask | psum_vld);
         row_done <= complete;
      end
   end

   always_comb begin
      act_next = '0;
      v_ext    = '0;
      for (int unsigned j = 0; j < COLS; j++) begin
         v_ext = {{2{row_reg[j][PSUM_W-1]}}, row_reg[j]};
`ifdef PSUM_REQ_BIAS_EN
         v_ext = v_ext + {{2{bias_cols[j][PSUM_W-1]}}, bias_cols[j]};
`endif
         act_next[j] = requant(v_ext, sh_q);
      end
   end

   // row_reg is read one edge after completion; the next row's column 0
   // may overwrite it on that same edge without corrupting this sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_vld  <= 1'b0;
         req_data <= '0;
      end else begin
         req_vld <= row_done & ~start;
         if (row_done)
            req_data <= act_next;
      end
   end

   assign pop     = out_valid & out_ready;
   assign push_ok = req_vld & (~fifo_full | pop);
   assign drop    = req_vld & fifo_full & ~pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt  <= '0;
         overflow <= 1'b0;
      end else if (start) begin
         row_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) row_cnt  <= row_cnt + 6'd1;
         if (drop)    overflow <= 1'b1;
      end
   end

   psum_row_fifo #(
      .DEPTH (DEPTH),
      .W     (ROW_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .push  (push_ok),
      .pop   (pop),
      .wdata ({row_cnt, req_data}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count_unused)
   );

   assign out_valid           = ~fifo_empty;
   assign {out_row, out_data} = fifo_rdata;
   assign done                = pop & (out_row == nrows_q - 6'd1);

endmodule
